// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width; never narrower than one bit so DIGIT == WIDTH still builds.
  function automatic int cnt_width(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice; zero latency.
// Exposes the carry into its MSB so the top can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c_in};
  end

  assign sum   = full[DIGIT-1:0];
  assign c_out = full[DIGIT];
  // sum bit = a ^ b ^ carry_in at every position, so the MSB carry-in falls out directly.
  assign c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, DIGIT bits per cycle; result valid WIDTH/DIGIT+1 cycles after accept.
// Result held in DONE until out_ready; a new operand pair may be accepted in the same cycle it drains.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int              NSLICE = WIDTH / DIGIT;
  localparam int              CW     = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0]   LAST   = CW'(NSLICE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             rdy_en;
  logic             c_out_r;
  logic             ovf_r;
  logic             load;
  logic             last;
  logic [DIGIT-1:0] s_sum;
  logic             s_cout;
  logic             s_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .c_in  (carry),
    .sum   (s_sum),
    .c_out (s_cout),
    .c_msb (s_cmsb)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rdy_en holds in_ready low until the first edge out of reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: in_ready = rdy_en;
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        in_ready = rdy_en & out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    load = in_valid & in_ready;
    if (load) state_nxt = RUN;
  end

  always_comb begin
    sum_nxt = sum_r >> DIGIT;
    sum_nxt[WIDTH-1 -: DIGIT] = s_sum;
  end

  // Subtract is folded in at capture: invert b and the borrow, then plain addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en  <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (load) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= c_in ^ sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        carry <= s_cout;
        cnt   <= cnt + 1'b1;
        sum_r <= sum_nxt;
        if (last) begin
          c_out_r <= s_cout;
          ovf_r   <= s_cout ^ s_cmsb;
        end
      end
    end
  end

  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at DIGIT = 1, 4 and 32 (WIDTH = 32).
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] a         [3];
  logic [31:0] b         [3];
  logic        c_in      [3];
  logic        sub       [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] sum       [3];
  logic        c_out     [3];
  logic        ovf       [3];

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_adder #(.WIDTH(32), .DIGIT(g == 0 ? 1 : (g == 1 ? 4 : 32))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .c_in      (c_in[g]),
      .sub       (sub[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
      .c_out     (c_out[g]),
      .ovf       (ovf[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic sb);
    logic [31:0] bb;
    logic        cc;
    logic [32:0] full;
    exp_t        e;
    bb   = sb ? ~bv : bv;
    cc   = sb ? ~ci : ci;
    full = {1'b0, av} + {1'b0, bb} + {32'd0, cc};
    e.s  = full[31:0];
    e.co = full[32];
    e.ov = (av[31] == bb[31]) && (full[31] != av[31]);
    exp_q.push_back(e);
  endtask

  task automatic scramble(input int k);
    a[k]    = $urandom;
    b[k]    = $urandom;
    c_in[k] = 1'($urandom_range(0, 1));
    sub[k]  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic sb);
    int w;
    a[k] = av; b[k] = bv; c_in[k] = ci; sub[k] = sb;
    in_valid[k] = 1'b1;
    push_model(av, bv, ci, sb);
    w = 0;
    while (!in_ready[k] && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready[k]) check("accept_timeout", 64'(in_ready[k]), 64'd1);
    tick();
    in_valid[k] = 1'b0;
    scramble(k);
  endtask

  task automatic compare_result(input int k, input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sum"},   64'(sum[k]),   64'(e.s));
    check({tag, "_c_out"}, 64'(c_out[k]), 64'(e.co));
    check({tag, "_ovf"},   64'(ovf[k]),   64'(e.ov));
  endtask

  // Called right after the accepting edge; counts cycles until out_valid.
  task automatic collect(input int k, input int nsl, input string tag);
    int t;
    t = 0;
    while (!out_valid[k] && t < 200) begin
      tick();
      t++;
      scramble(k);
    end
    check({tag, "_latency"}, 64'(t + 1), 64'(nsl + 1));
    compare_result(k, tag);
    if (out_ready[k]) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      a[k] = '0; b[k] = '0; c_in[k] = 1'b0; sub[k] = 1'b0;
    end
    repeat (3) tick();

    check("rst_in_ready",  64'(in_ready[1]),  64'd0);
    check("rst_out_valid", 64'(out_valid[1]), 64'd0);
    check("rst_sum",       64'(sum[1]),       64'd0);
    check("rst_c_out",     64'(c_out[1]),     64'd0);
    check("rst_ovf",       64'(ovf[1]),       64'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(in_ready[1]), 64'd0);
    tick();
    check("rdy_after_edge",  64'(in_ready[1]), 64'd1);

    drive_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    collect(1, 8, "add_wrap");
    drive_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    collect(1, 8, "add_ovf");
    drive_op(1, 32'd5, 32'd7, 1'b1, 1'b1);
    collect(1, 8, "sub_borrow");
    drive_op(1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    collect(1, 8, "sub_ovf");

    // Backpressure with junk on in_valid, then drain and accept in the same cycle.
    out_ready[1] = 1'b0;
    drive_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    in_valid[1] = 1'b1;
    t = 0;
    while (!out_valid[1] && t < 200) begin
      tick();
      t++;
      scramble(1);
    end
    check("bp_latency", 64'(t + 1), 64'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      scramble(1);
      check("bp_valid_held", 64'(out_valid[1]), 64'd1);
      check("bp_in_ready",   64'(in_ready[1]),  64'd0);
      check("bp_sum_held",   64'(sum[1]),       64'(exp_q[0].s));
    end
    out_ready[1] = 1'b1;
    a[1] = 32'd100; b[1] = 32'd23; c_in[1] = 1'b0; sub[1] = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready[1]), 64'd1);
    compare_result(1, "bp");
    push_model(32'd100, 32'd23, 1'b0, 1'b1);
    tick();
    in_valid[1] = 1'b0;
    scramble(1);
    collect(1, 8, "b2b");

    // Reset in the middle of RUN aborts without emitting a result.
    a[1] = 32'hAAAA_AAAA; b[1] = 32'h5555_5555; c_in[1] = 1'b1; sub[1] = 1'b0;
    in_valid[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid[1]), 64'd0);
    check("midrst_in_ready",  64'(in_ready[1]),  64'd0);
    check("midrst_sum",       64'(sum[1]),       64'd0);
    check("midrst_c_out",     64'(c_out[1]),     64'd0);
    check("midrst_ovf",       64'(ovf[1]),       64'd0);
    tick();
    rst_n = 1'b1;
    drive_op(1, 32'd3, 32'd4, 1'b0, 1'b0);
    check("post_rst_exp", 64'(exp_q[0].s), 64'd7);
    collect(1, 8, "post_rst");

    // DIGIT = WIDTH: two-cycle latency.
    drive_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    collect(2, 1, "d32_wrap");

    for (int k = 0; k < 3; k++) begin
      int nsl;
      nsl = (k == 0) ? 32 : ((k == 1) ? 8 : 1);
      for (int i = 0; i < 1000; i++) begin
        drive_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        collect(k, nsl, "rand");
      end
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT, with DIGIT >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry out of the MSB (raw adder carry, also in subtract mode).
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE; a transfer occurs on a cycle with valid and ready both high.
REQ-016 in_ready SHALL be 1 in IDLE, and also in DONE in the same cycle that out_ready=1; it SHALL be 0 otherwise.
REQ-017 On an input transfer the block SHALL capture a, b, c_in and sub, clear the digit counter, and go to RUN.
REQ-018 Add mode SHALL compute {c_out,sum} = a + b + c_in; subtract mode SHALL compute a + ~b + ~c_in, i.e. sum = a - b - c_in modulo 2^WIDTH.
REQ-019 In RUN, each cycle SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry from the previous slice; slice results SHALL be shifted into the sum register.
REQ-020 RUN SHALL last exactly WIDTH/DIGIT cycles; out_valid SHALL rise on the cycle after the last slice, giving latency from input transfer to out_valid = WIDTH/DIGIT + 1 cycles.
REQ-021 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, computed in the final slice.
REQ-022 In DONE, out_valid, sum, c_out and ovf SHALL be held stable until out_ready=1.
REQ-023 On an output transfer with in_valid=0 the block SHALL go to IDLE; with in_valid=1 it SHALL accept the new operands in that same cycle and go directly to RUN (no bubble).
REQ-024 in_valid while in RUN SHALL be ignored, since in_ready=0; inputs SHALL NOT be sampled outside transfers.
REQ-025 When DIGIT = WIDTH, RUN SHALL last 1 cycle and the latency SHALL be 2 cycles.
REQ-026 Changing sub or c_in after capture SHALL have no effect on the operation in flight.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force state IDLE, counter 0, carry 0, sum 0, c_out 0, ovf 0, out_valid 0 and in_ready 0 while asserted.
REQ-028 in_ready SHALL rise to 1 on the first clock edge after rst_n deasserts.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no result emitted; the next result SHALL be for operands accepted after reset.

Structure
REQ-030 Package adder_pkg SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and a function computing the counter width, clog2(WIDTH/DIGIT) with a minimum of 1.
REQ-031 Sub-module digit_adder SHALL be a purely combinational DIGIT-bit adder with outputs sum, carry out, and carry into its MSB; it SHALL be instantiated once.
REQ-032 The top level SHALL contain only the FSM, counter, operand shift registers, carry register and handshake logic.

Verification (WIDTH=32, DIGIT=4 unless stated)
REQ-033 Add: a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 -> after 9 cycles out_valid=1, sum=0x00000000, c_out=1, ovf=0.
REQ-034 Overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, c_out=0, ovf=1; subtract a=5, b=7, c_in=1, sub=1 -> sum=0xFFFFFFFD, c_out=0, ovf=0.
REQ-035 Backpressure plus back-to-back: hold out_ready=0 for 5 cycles -> result stable and in_ready=0; then out_ready=1 with in_valid=1 -> next operation starts the same cycle and the next out_valid appears 9 cycles later.
REQ-036 Reset mid-RUN: pulse rst_n low at slice 3 -> all outputs are 0 immediately with no out_valid; the next operation 3+4 yields sum=7.
REQ-037 Parameter sweep: DIGIT in {1, 4, 32}, 1000 random operands each -> every result matches the reference model of REQ-018/REQ-021, with latency WIDTH/DIGIT+1.
